// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // DEAD: all anodes off at the start of a slot; ON: selected digit lit.
    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load side (packed BCD word + strobe) and display side (anodes, segments,
// frame tick) of the scan driver. The driver uses the slave modport.
interface seg7_scan_driver_if;

    logic        bcd_valid;
    logic [15:0] bcd_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    modport master (
        output bcd_valid,
        output bcd_in,
        input  an,
        input  seg,
        input  frame_tick
    );

    modport slave (
        input  bcd_valid,
        input  bcd_in,
        output an,
        output seg,
        output frame_tick
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibbles above 9 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Map one nibble to its segment pattern.
    always_comb begin
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment scan driver.
// Each digit slot lasts SCAN_DIV cycles, the first DEAD_CYC of which keep
// all anodes off. New values are committed only at frame boundaries.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int              CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   DEAD_LIM = CW'(DEAD_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic [15:0]   disp_q, disp_d;
    state_e        state_q, state_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    blank;
    logic [3:0]    nibble_sel;
    logic [6:0]    dec_seg;

    // Prescaler, digit index and the pending/display commit logic.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        cnt_d      = cnt_q + 1'b1;
        dig_d      = dig_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        disp_d     = disp_q;

        slot_end = (cnt_q == CNT_MAX);
        boundary = slot_end && (dig_q == 2'd3);

        if (slot_end) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end

        if (boundary) begin
            // A load landing on the boundary itself bypasses the pending slot.
            if (bus.bcd_valid) begin
                disp_d = bus.bcd_in;
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = pend_val_q;
                pend_d = 1'b0;
            end
        end else if (bus.bcd_valid) begin
            pend_val_d = bus.bcd_in;
            pend_d     = 1'b1;
        end
    end

    // Leading-zero blanking mask, evaluated on the value about to be shown.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (disp_d[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_d[11:8] == 4'd0);
        blank[1] = blank[2] && (disp_d[7:4] == 4'd0);
    end
`else
    assign blank = 4'b0000;
`endif

    assign nibble_sel = disp_d[{dig_d, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .nibble_i (nibble_sel),
        .seg_o    (dec_seg)
    );

    // FSM next state and output decode, both taken from next-state counters
    // so the registered outputs line up with cnt/dig without extra lag.
    always_comb begin
        state_d      = state_q;
        an_d         = 4'b1111;
        seg_d        = SEG_OFF;
        frame_tick_d = boundary;

        case (state_q)
            DEAD:    if (cnt_d >= DEAD_LIM) state_d = ON;
            ON:      if (cnt_d <  DEAD_LIM) state_d = DEAD;
            default: state_d = DEAD;
        endcase

        if (state_d == ON && !blank[dig_d]) begin
            an_d  = ~(4'b0001 << dig_d);
            seg_d = dec_seg;
        end
    end

    // State and output registers; reset blanks the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dig_q        <= 2'd0;
            pend_val_q   <= 16'h0000;
            pend_q       <= 1'b0;
            disp_q       <= 16'h0000;
            state_q      <= DEAD;
            an_q         <= 4'b1111;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            pend_val_q   <= pend_val_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            state_q      <= state_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with SCAN_DIV=8, DEAD_CYC=2.
// A reference model predicts each cycle's display outputs; predictions are
// queued when stimulus is applied and popped when the DUT output is sampled.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int DC = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    logic clk;
    logic rst_n;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    exp_t exp_q[$];

    // Reference model state
    int          m_cnt, m_dig;
    logic [15:0] m_disp, m_pval;
    logic        m_pend, m_tick;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (n > 4'd9) return 7'h3F;
        return tbl[n];
    endfunction

    function automatic bit ref_blank(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        return (v >> (4 * d)) == 16'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.tick = m_tick;
        e.an   = 4'b1111;
        e.seg  = 7'h7F;
        if (m_cnt >= DC && !ref_blank(m_disp, m_dig)) begin
            e.an  = 4'b1111 & ~(4'b0001 << m_dig);
            e.seg = ref_seg(m_disp[4*m_dig +: 4]);
        end
        return e;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_dig  = 0;
        m_disp = 16'h0;
        m_pval = 16'h0;
        m_pend = 1'b0;
        m_tick = 1'b0;
        exp_q.delete();
    endtask

    // One clock: apply stimulus, advance the model, compare at the negedge.
    task automatic step(input logic v, input logic [15:0] d);
        bit   bnd;
        exp_t e;
        bus.bcd_valid = v;
        bus.bcd_in    = d;
        @(posedge clk);
        bnd = (m_cnt == SD - 1) && (m_dig == 3);
        if (bnd) begin
            if (v) begin
                m_disp = d;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end
        end else if (v) begin
            m_pval = d;
            m_pend = 1'b1;
        end
        m_tick = bnd;
        if (m_cnt == SD - 1) begin
            m_cnt = 0;
            m_dig = (m_dig + 1) % 4;
        end else begin
            m_cnt++;
        end
        exp_q.push_back(predict());
        @(negedge clk);
        bus.bcd_valid = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("an d%0d c%0d", m_dig, m_cnt),   {28'd0, bus.an},  {28'd0, e.an});
            check($sformatf("seg d%0d c%0d", m_dig, m_cnt),  {25'd0, bus.seg}, {25'd0, e.seg});
            check($sformatf("tick d%0d c%0d", m_dig, m_cnt), {31'd0, bus.frame_tick}, {31'd0, e.tick});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    // Idle until the model sits at the requested slot position (bounded).
    task automatic run_to(input int c, input int d);
        int budget;
        budget = 4 * SD + 1;
        while (!(m_cnt == c && m_dig == d) && budget > 0) begin
            step(1'b0, 16'h0);
            budget--;
        end
        if (budget == 0) check("run_to_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.bcd_valid = 1'b0;
        bus.bcd_in    = 16'h0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_an",   {28'd0, bus.an},  32'hF);
        check("reset_seg",  {25'd0, bus.seg}, 32'h7F);
        check("reset_tick", {31'd0, bus.frame_tick}, 32'd0);
        rst_n = 1'b1;

        // Post-reset frames showing zero
        idle(2 * 4 * SD);

        // Mid-frame load of 0x1234, then two frames
        run_to(3, 1);
        step(1'b1, 16'h1234);
        idle(2 * 4 * SD);

        // Leading-zero patterns
        run_to(5, 0);
        step(1'b1, 16'h0042);
        idle(2 * 4 * SD);
        run_to(2, 2);
        step(1'b1, 16'h00A5);
        idle(2 * 4 * SD);

        // Last load in a frame wins
        run_to(1, 0);
        step(1'b1, 16'h1111);
        run_to(5, 2);
        step(1'b1, 16'h2222);
        idle(2 * 4 * SD);

        // Load on the boundary cycle itself
        run_to(SD - 1, 3);
        step(1'b1, 16'h3333);
        idle(4 * SD);

        // Asynchronous reset mid ON phase of digit 2
        run_to(4, 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_an",  {28'd0, bus.an},  32'hF);
        check("async_rst_seg", {25'd0, bus.seg}, 32'h7F);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("held_rst_an", {28'd0, bus.an}, 32'hF);
        rst_n = 1'b1;
        idle(2 * 4 * SD);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Downstream consumer of the 16-bit binary-to-BCD converter.
- Captures a packed 4-digit BCD word and drives a time-multiplexed, common-anode 4-digit seven-segment display.
- Scans digits with a programmable slot length and a dead-time between slots to suppress ghosting.
- Commits new values only at frame boundaries so a displayed frame never mixes two values.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range ≥2.
- DEAD_CYC, 500, all-anodes-off cycles at the start of each slot; legal range 0..SCAN_DIV-1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bcd_valid  in  1  single-cycle load strobe
- bcd_in  in  16  packed BCD; [3:0] is the ones digit, [15:12] the thousands digit
- an  out  4  active-low anodes; an[0] is the rightmost digit (ones)
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- frame_tick  out  1  one-cycle pulse on each frame boundary

## Operation
State held by the block:
- Prescaler cnt: 0..SCAN_DIV-1.
- Digit index dig: 0..3.
- Pending register pend_val with flag pend.
- Display register disp.
- FSM state: DEAD when cnt<DEAD_CYC, otherwise ON.

Scanning and loading:
- cnt increments every cycle.
- When cnt==SCAN_DIV-1: cnt→0 and dig→dig+1, wrapping 3→0.
- A frame boundary is the cycle with cnt==SCAN_DIV-1 and dig==3.
- bcd_valid on a non-boundary cycle: pend_val←bcd_in and pend←1. A later load in the same frame overwrites the earlier one (last wins).
- On a boundary cycle:
  - if bcd_valid: disp←bcd_in, pend←0;
  - else if pend: disp←pend_val, pend←0;
  - else disp is unchanged.

Decoding (nibble → seg):
- 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19
- 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10
- Any nibble >9 → 0x3F (dash).

Output rules:
- DEAD: an=4'b1111, seg=0x7F.
- ON: an has only bit dig low, and seg shows the decode of disp nibble dig.
- A blanked digit (see Configuration) keeps an=1111 and seg=0x7F for its whole slot.

## Timing
- All outputs are registered and derived from next-state values. an/seg therefore match the current cnt/dig with no extra cycle of lag.
- Reset values:
  - an=4'b1111, seg=0x7F, frame_tick=0
  - cnt=0, dig=0, disp=0, pend_val=0, pend=0
- Reset is asynchronous: asserting rst_n mid-slot blanks the outputs immediately. After release, scanning restarts at cnt=0, dig=0 with disp=0.
- Load latency:
  - bcd_valid on a boundary cycle is visible from the next cycle.
  - Otherwise it becomes visible at the next frame boundary, worst case 4·SCAN_DIV cycles.
- frame_tick is high in the cycle after a boundary (cnt=0, dig=0).
- DEAD_CYC=0 means no dead phase: an anode is active in every cycle of the slot.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits 3, 2 and 1 are blanked when their nibble is 0 and every more-significant nibble is also 0.
  - Digit 0 is never blanked.
  - A nibble >9 counts as nonzero.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always driven.

## Structure
- Package seg7_pkg holds:
  - the ten digit segment constants, SEG_DASH (0x3F) and SEG_OFF (0x7F);
  - the FSM state enum {DEAD, ON}.
- Sub-module bcd_to_seg7 is a purely combinational nibble→seg decoder, instantiated once on the selected nibble.
- Top-level RTL holds the counters, FSM, load/commit logic, blanking mask and output registers.

## Test plan
All scenarios use SCAN_DIV=8 and DEAD_CYC=2.
- Reset check:
  - during reset: an=1111, seg=0x7F;
  - after release with blanking enabled: only the dig=0 slot lights, an=1110 and seg=0x40 for cnt 2..7;
  - with blanking disabled: all four slots show 0x40.
- Load 0x1234 mid-frame:
  - nothing changes until the boundary;
  - next frame: dig0 seg=0x19, dig1 0x30, dig2 0x24, dig3 0x79, each with its own single anode low for cnt 2..7;
  - an=1111 for cnt 0..1 of every slot.
- With LEADING_ZERO_BLANK_EN, load 0x0042:
  - dig3 and dig2 slots stay an=1111;
  - dig1 shows 0x19 and dig0 shows 0x24.
- With LEADING_ZERO_BLANK_EN, load 0x00A5:
  - dig2 and dig3 are blanked;
  - dig1 shows 0x3F and dig0 shows 0x12.
- Load ordering:
  - 0x1111 then 0x2222 in the same frame: only 0x2222 is displayed at the next boundary and frame_tick pulses once;
  - 0x3333 on the boundary cycle itself: displayed in the very next frame.
- Assert rst_n low at cnt=4 of the dig=2 ON phase:
  - an=1111 immediately, without waiting for a clock edge;
  - after release, the first ON cycle is cnt=2, dig=0 with disp=0.
